// File: rtl/alu_exec_unit_pkg.sv
// Shared ALU control codes and handshake FSM encodings for the execute stage.
// The ALU control decoder imports this same package so the codes have one source.
package alu_exec_unit_pkg;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_XOR  = 3'b001;
    localparam logic [2:0] ALU_SLL  = 3'b010;
    localparam logic [2:0] ALU_ADD  = 3'b011;
    localparam logic [2:0] ALU_SUB  = 3'b100;
    localparam logic [2:0] ALU_MUL  = 3'b101;
    localparam logic [2:0] ALU_ADDI = 3'b110;
    localparam logic [2:0] ALU_SRAI = 3'b111;

    localparam logic [1:0] ST_IDLE     = 2'b00;
    localparam logic [1:0] ST_MUL_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE     = 2'b10;

    function automatic logic is_mul(input logic [2:0] code);
        return (code == ALU_MUL);
    endfunction

endpackage

// File: rtl/alu_exec_unit_mul_iter.sv
// Iterative shift-add multiplier: one partial product per clock, always WIDTH
// steps so latency does not depend on operand values. Low WIDTH bits only.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplr;

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_last;

    assign w_addend   = r_mplr[0] ? r_mcand : '0;
    assign w_acc_next = r_acc + w_addend;
    assign w_last     = r_busy && (r_cnt == LAST_STEP);

    // The done pulse coincides with the final step so the caller can register
    // the accumulator including that last partial product on the same edge.
    assign busy_o    = r_busy;
    assign done_o    = w_last;
    assign product_o = w_acc_next;

    // Load operands on start, then one shift-add step per edge while busy.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_mcand <= '0;
            r_mplr  <= '0;
        end else if (start_i) begin
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_mcand <= a_i;
            r_mplr  <= b_i;
        end else if (r_busy) begin
            r_acc   <= w_acc_next;
            r_mcand <= r_mcand << 1;
            r_mplr  <= r_mplr >> 1;
            if (w_last) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready on both sides. Single-cycle ops register
// their result on the accept edge; MUL is handed to the iterative multiplier.
//
// state    | meaning
// IDLE     | no result held, ready for a request
// MUL_BUSY | multiplier stepping, requests refused
// DONE     | result valid, held until downstream takes it
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       ALUCtr_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o
);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_data;
    logic             r_zero;

    logic               w_accept;
    logic               w_is_mul;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0]   w_alu;
    logic               w_mul_start;
    logic               w_mul_busy;
    logic               w_mul_done;
    logic [WIDTH-1:0]   w_mul_product;

    // In DONE the slot frees up in the same cycle downstream takes the result.
    assign ready_o     = (r_state == ST_IDLE) || ((r_state == ST_DONE) && ready_i);
    assign w_accept    = valid_i && ready_o;
    assign w_is_mul    = is_mul(ALUCtr_i);
    assign w_mul_start = w_accept && w_is_mul;
    assign w_shamt     = data2_i[SHAMT_W-1:0];

    assign valid_o = (r_state == ST_DONE);
    assign data_o  = r_data;
    assign zero_o  = r_zero;

    // Single-cycle datapath; MUL result comes from the multiplier instead.
    always_comb begin
        w_alu = '0;
        case (ALUCtr_i)
            ALU_AND:  w_alu = data1_i & data2_i;
            ALU_XOR:  w_alu = data1_i ^ data2_i;
            ALU_SLL:  w_alu = data1_i << w_shamt;
            ALU_ADD:  w_alu = data1_i + data2_i;
            ALU_SUB:  w_alu = data1_i - data2_i;
            ALU_ADDI: w_alu = data1_i + data2_i;
            ALU_SRAI: w_alu = WIDTH'($signed(data1_i) >>> w_shamt);
            default:  w_alu = '0;
        endcase
    end

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (w_mul_start),
        .a_i       (data1_i),
        .b_i       (data2_i),
        .busy_o    (w_mul_busy),
        .done_o    (w_mul_done),
        .product_o (w_mul_product)
    );

    // Handshake FSM; result and zero flag are registered together.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_zero  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_state <= ST_MUL_BUSY;
                        end else begin
                            r_state <= ST_DONE;
                            r_data  <= w_alu;
                            r_zero  <= (w_alu == '0);
                        end
                    end
                end
                ST_MUL_BUSY: begin
                    if (w_mul_done) begin
                        r_state <= ST_DONE;
                        r_data  <= w_mul_product;
                        r_zero  <= (w_mul_product == '0);
                    end else if (!w_mul_busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    if (ready_i) begin
                        if (w_accept) begin
                            if (w_is_mul) begin
                                r_state <= ST_MUL_BUSY;
                            end else begin
                                r_data <= w_alu;
                                r_zero <= (w_alu == '0);
                            end
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: single-cycle ops, MUL latency and busy
// refusal, back-pressure hold, and reset in the middle of a multiply.
module tb_alu_exec_unit;

    logic        clk_i;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [2:0]  ALUCtr_i;
    logic [31:0] data1_i;
    logic [31:0] data2_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] data_o;
    logic        zero_o;

    int n_cmp;
    int n_bad;

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .ALUCtr_i (ALUCtr_i),
        .data1_i  (data1_i),
        .data2_i  (data2_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .data_o   (data_o),
        .zero_o   (zero_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a single-cycle op at a negedge, check it on the accept edge + 1.
    task automatic run_op(input string tag, input logic [2:0] code,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        @(negedge clk_i);
        chk({tag, "_rdy"}, {31'd0, ready_o}, 32'd1);
        valid_i  = 1'b1;
        ALUCtr_i = code;
        data1_i  = a;
        data2_i  = b;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        chk({tag, "_vld"},  {31'd0, valid_o}, 32'd1);
        chk({tag, "_data"}, data_o, exp);
        chk({tag, "_zero"}, {31'd0, zero_o}, {31'd0, (exp == 32'd0)});
        @(posedge clk_i);
        #1;
        chk({tag, "_idle"}, {31'd0, valid_o}, 32'd0);
    endtask

    // Accept a MUL and measure edges until valid_o, holding valid_i meanwhile.
    task automatic run_mul(input string tag, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        int edges;
        int busy;
        edges = 0;
        busy  = 0;
        @(negedge clk_i);
        valid_i  = 1'b1;
        ALUCtr_i = 3'b101;
        data1_i  = a;
        data2_i  = b;
        @(posedge clk_i);
        #1;
        if (!ready_o) busy++;
        while (!valid_o && edges < 40) begin
            @(posedge clk_i);
            #1;
            edges++;
            if (!ready_o && !valid_o) busy++;
        end
        valid_i = 1'b0;
        chk({tag, "_lat"},  edges, 32'd32);
        chk({tag, "_busy"}, busy, 32'd32);
        chk({tag, "_data"}, data_o, exp);
        chk({tag, "_vld"},  {31'd0, valid_o}, 32'd1);
        @(posedge clk_i);
        #1;
        chk({tag, "_idle"}, {31'd0, valid_o}, 32'd0);
    endtask

    initial begin
        int pulses;
        n_cmp    = 0;
        n_bad    = 0;
        rst_i    = 1'b1;
        valid_i  = 1'b0;
        ready_i  = 1'b1;
        ALUCtr_i = 3'b000;
        data1_i  = '0;
        data2_i  = '0;
        #1 rst_i = 1'b0;
        #1;
        chk("rst0_vld",  {31'd0, valid_o}, 32'd0);
        chk("rst0_data", data_o, 32'd0);
        chk("rst0_zero", {31'd0, zero_o}, 32'd1);
        chk("rst0_rdy",  {31'd0, ready_o}, 32'd1);
        @(negedge clk_i);
        rst_i = 1'b1;

        run_op("add",   3'b011, 32'd7, 32'd5, 32'd12);
        run_op("sub",   3'b100, 32'd5, 32'd5, 32'd0);
        run_op("xor",   3'b001, 32'hF0F0_0000, 32'h0FF0_0000, 32'hFF00_0000);
        run_op("sll",   3'b010, 32'd1, 32'd31, 32'h8000_0000);
        run_op("sll0",  3'b010, 32'h0000_1234, 32'd32, 32'h0000_1234);
        run_op("srai",  3'b111, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF);
        run_op("srai0", 3'b111, 32'h8765_4321, 32'd0, 32'h8765_4321);
        run_op("addi",  3'b110, 32'd10, 32'hFFFF_FFFF, 32'd9);
        run_op("and",   3'b000, 32'hF0F0_F0F0, 32'h0FF0_FF00, 32'h00F0_F000);

        // Result held in DONE mid-cycle, then reset asserted asynchronously.
        @(negedge clk_i);
        valid_i  = 1'b1;
        ALUCtr_i = 3'b011;
        data1_i  = 32'd40;
        data2_i  = 32'd2;
        ready_i  = 1'b0;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        chk("pre_rst_data", data_o, 32'd42);
        #2 rst_i = 1'b0;
        #1;
        chk("arst_vld",  {31'd0, valid_o}, 32'd0);
        chk("arst_data", data_o, 32'd0);
        chk("arst_zero", {31'd0, zero_o}, 32'd1);
        chk("arst_rdy",  {31'd0, ready_o}, 32'd1);
        @(negedge clk_i);
        rst_i   = 1'b1;
        ready_i = 1'b1;

        run_mul("mul", 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
        run_mul("mul0", 32'h1234_5678, 32'd0, 32'd0);

        // Back-pressure: AND result held for 5 cycles with a waiting ADD.
        @(negedge clk_i);
        ready_i  = 1'b0;
        valid_i  = 1'b1;
        ALUCtr_i = 3'b000;
        data1_i  = 32'h0000_0FF0;
        data2_i  = 32'h0000_00FF;
        @(posedge clk_i);
        #1;
        ALUCtr_i = 3'b011;
        data1_i  = 32'd100;
        data2_i  = 32'd23;
        chk("bp_first", data_o, 32'h0000_00F0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i);
            #1;
            chk("bp_hold", data_o, 32'h0000_00F0);
            chk("bp_vld",  {31'd0, valid_o}, 32'd1);
            chk("bp_rdy",  {31'd0, ready_o}, 32'd0);
        end
        @(negedge clk_i);
        ready_i = 1'b1;
        #1;
        chk("bp_rdy_rel", {31'd0, ready_o}, 32'd1);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        chk("b2b_vld",  {31'd0, valid_o}, 32'd1);
        chk("b2b_data", data_o, 32'd123);
        chk("b2b_zero", {31'd0, zero_o}, 32'd0);
        @(posedge clk_i);
        #1;
        chk("b2b_idle", {31'd0, valid_o}, 32'd0);

        // Reset at step 10 of a multiply: no result, next MUL starts fresh.
        @(negedge clk_i);
        valid_i  = 1'b1;
        ALUCtr_i = 3'b101;
        data1_i  = 32'd12345;
        data2_i  = 32'd678;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("mrst_rdy", {31'd0, ready_o}, 32'd1);
        chk("mrst_vld", {31'd0, valid_o}, 32'd0);
        @(negedge clk_i);
        rst_i  = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clk_i);
            #1;
            if (valid_o) pulses++;
        end
        chk("mrst_nopulse", pulses, 32'd0);
        run_mul("mul2", 32'd12345, 32'd678, 32'd8369910);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish before 200000");
        $fatal(1);
    end

endmodule
